// File: rtl/mips_lsu.sv
// -----------------------------------------------------------------------------
// mips_lsu
//   MEM-stage load/store unit. Takes the ALU result as effective address and rt
//   as store data. Each access becomes one single-beat req/ack transaction on the
//   data-memory bus. Load data is sign- or zero-extended for writeback.
//   Misaligned/illegal accesses and bus timeouts are reported with the
//   completion pulse.
//
// Parameters
//   TIMEOUT_CYCLES : max REQ cycles without mem_ack before a bus error (0 = off)
//   CNT_WIDTH      : timeout counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   op_valid              : memory op present in MEM this cycle
//   mem_read, mem_write   : load / store request
//   size                  : 00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned         : 1 zero-extends loads, 0 sign-extends
//   addr, store_data      : effective address, rt value
//   mem_req, mem_we       : bus request, write strobe
//   mem_addr              : word-aligned bus address
//   mem_be                : byte enables, bit k = lane k (little-endian)
//   mem_wdata             : lane-replicated store data
//   mem_rdata, mem_ack    : bus read data, transaction complete
//   load_data             : extended load result (held until next load)
//   done                  : one-cycle completion pulse
//   stall                 : holds the upstream pipeline
//   exc, exc_code         : exception flag/code, valid only with done
// -----------------------------------------------------------------------------
module mips_lsu #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        exc,
    output logic [1:0]  exc_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ALIGN   = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    // The timeout fires in the REQ cycle whose count equals TIMEOUT_CYCLES-1,
    // so mem_req is high for exactly TIMEOUT_CYCLES cycles.
    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           size_q;
    logic [1:0]           lsb_q;
    logic                 uns_q;

    logic        accept;
    logic        illegal;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rdata_ext;

    assign accept  = op_valid & (mem_read | mem_write);
    assign illegal = (mem_read & mem_write)
                   | (size == 2'b11)
                   | ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                   | ((size == SZ_HALF) && addr[0]);

    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    // Stall is combinational on op_valid in IDLE so the very first cycle of an
    // access already freezes EX; it is never asserted in DONE.
    assign stall = ((state == S_IDLE) && accept) || (state == S_REQ);

    // Byte enables and replicated store data for the incoming access.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        be_next    = 4'b0000;
        wdata_next = store_data;
        case (size)
            SZ_BYTE: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                be_next    = 4'b1111;
                wdata_next = store_data;
            end
            default: ;
        endcase
    end

    // Lane extraction and extension of read data, using the access shape
    // captured at accept time.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = lsb_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rdata_ext = mem_rdata;
        case (lsb_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        case (size_q)
            SZ_BYTE: rdata_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: rdata_ext = mem_rdata;
        endcase
    end

    // Control FSM with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the bus/data registers are reset too; a reset mid-transaction
            // must leave a clean, deterministic bus.
            state     <= S_IDLE;
            cnt       <= '0;
            size_q    <= SZ_BYTE;
            lsb_q     <= 2'b00;
            uns_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            load_data <= 32'h0;
            done      <= 1'b0;
            exc       <= 1'b0;
            exc_code  <= EXC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    // A late mem_ack arriving here is ignored.
                    if (accept) begin
                        if (illegal) begin
                            // No bus cycle: report on the very next cycle.
                            state    <= S_DONE;
                            done     <= 1'b1;
                            exc      <= 1'b1;
                            exc_code <= EXC_ALIGN;
                        end else begin
                            state     <= S_REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            size_q    <= size;
                            lsb_q     <= addr[1:0];
                            uns_q     <= load_unsigned;
                        end
                    end
                end

                S_REQ: begin
                    // Ack beats a timeout in the same cycle.
                    if (mem_ack) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            load_data <= rdata_ext;
                        end
                    end else if (timeout_hit) begin
                        state    <= S_DONE;
                        mem_req  <= 1'b0;
                        done     <= 1'b1;
                        exc      <= 1'b1;
                        exc_code <= EXC_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    state    <= S_IDLE;
                    done     <= 1'b0;
                    exc      <= 1'b0;
                    exc_code <= EXC_NONE;
                end

                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    done    <= 1'b0;
                    exc     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// -----------------------------------------------------------------------------
// tb_mips_lsu
//   Self-checking bench for mips_lsu (TIMEOUT_CYCLES = 4). Directed accesses
//   from the test plan followed by randomized accesses, all compared against a
//   behavioural model of byte lanes, replication, extension, legality and
//   transaction latency.
// -----------------------------------------------------------------------------
module tb_mips_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        exc;
    logic [1:0]  exc_code;

    always #5 clk = ~clk;

    mips_lsu #(
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .size         (size),
        .load_unsigned(load_unsigned),
        .addr         (addr),
        .store_data   (store_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .load_data    (load_data),
        .done         (done),
        .stall        (stall),
        .exc          (exc),
        .exc_code     (exc_code)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_load    = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit is_illegal(input bit rd, input bit wr, input logic [1:0] sz,
                                      input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (sz == 2'b11) return 1'b1;
        return (int'(a % 4) % nbytes(sz)) != 0;
    endfunction

    // Lowest byte lane touched: the address offset rounded down to the size.
    function automatic int lane_of(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a % 4) / nbytes(sz)) * nbytes(sz);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        return 4'(((1 << nbytes(sz)) - 1) << lane_of(sz, a));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input bit uns, input logic [31:0] rd);
        longint unsigned v, mask;
        int n;
        n    = nbytes(sz);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = (64'(rd) >> (8 * lane_of(sz, a))) & mask;
        if (!uns && (((v >> (8 * n - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- one complete access ----------------
    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a, input logic [31:0] sd,
                          input int ack_delay, input logic [31:0] rdata);
        bit ill, timed_out, acked;
        int exp_lat, exp_reqs, c, reqs;
        ill       = is_illegal(rd, wr, sz, a);
        timed_out = !ill && (ack_delay >= TO);
        acked     = !ill && !timed_out;
        exp_lat   = ill ? 1 : (timed_out ? TO + 1 : ack_delay + 2);
        exp_reqs  = ill ? 0 : (timed_out ? TO : ack_delay + 1);

        op_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz;
        load_unsigned = uns; addr = a; store_data = sd; mem_ack = 1'b0;
        #1;
        check({tag, ".stall_accept"}, 32'(stall), 32'd1);

        c = 0;
        reqs = 0;
        while (1) begin
            @(posedge clk); #1;
            c++;
            mem_ack = 1'b0;
            if (done === 1'b1) break;
            if (c > 20) begin
                check({tag, ".done_timeout"}, 32'(done), 32'd1);
                break;
            end
            check({tag, ".req"},   32'(mem_req), 32'd1);
            check({tag, ".we"},    32'(mem_we),  32'(wr));
            check({tag, ".addr"},  mem_addr,     a & 32'hFFFF_FFFC);
            check({tag, ".be"},    32'(mem_be),  32'(model_be(sz, a)));
            check({tag, ".wdata"}, mem_wdata,    model_wdata(sz, sd));
            check({tag, ".stall"}, 32'(stall),   32'd1);
            if (mem_req === 1'b1) reqs++;
            // Upstream noise while busy must be ignored.
            op_valid      = 1'($urandom_range(0, 1));
            mem_read      = 1'($urandom_range(0, 1));
            mem_write     = 1'($urandom_range(0, 1));
            size          = 2'($urandom_range(0, 3));
            load_unsigned = 1'($urandom_range(0, 1));
            addr          = $urandom;
            store_data    = $urandom;
            mem_ack       = (c - 1 == ack_delay);
            mem_rdata     = mem_ack ? rdata : $urandom;
        end

        check({tag, ".latency"},  32'(c),        32'(exp_lat));
        check({tag, ".req_cyc"},  32'(reqs),     32'(exp_reqs));
        check({tag, ".done_req"}, 32'(mem_req),  32'd0);
        check({tag, ".done_stl"}, 32'(stall),    32'd0);
        check({tag, ".exc"},      32'(exc),      32'(ill || timed_out));
        check({tag, ".exc_code"}, 32'(exc_code), 32'(ill ? 2'b01 : (timed_out ? 2'b10 : 2'b00)));
        if (acked && rd) exp_load = model_load(sz, a, uns, rdata);
        check({tag, ".load"},     load_data,     exp_load);

        op_valid = 1'b0;
        mem_ack  = 1'b0;
        @(posedge clk); #1;
        check({tag, ".done_clr"}, 32'(done),     32'd0);
        check({tag, ".exc_clr"},  32'(exc),      32'd0);
        check({tag, ".code_clr"}, 32'(exc_code), 32'd0);
        check({tag, ".idle_req"}, 32'(mem_req),  32'd0);
    endtask

    // Hard stop in case the sequence itself hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'b00; load_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.req",   32'(mem_req),   32'd0);
        check("rst.we",    32'(mem_we),    32'd0);
        check("rst.addr",  mem_addr,       32'h0);
        check("rst.be",    32'(mem_be),    32'd0);
        check("rst.wdata", mem_wdata,      32'h0);
        check("rst.load",  load_data,      32'h0);
        check("rst.done",  32'(done),      32'd0);
        check("rst.stall", 32'(stall),     32'd0);
        check("rst.exc",   32'(exc),       32'd0);
        check("rst.code",  32'(exc_code),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // op_valid without read/write, and read without op_valid: no accept.
        op_valid = 1'b1; #1;
        check("noop.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("noop.req",  32'(mem_req), 32'd0);
        check("noop.done", 32'(done),    32'd0);
        op_valid = 1'b0; mem_read = 1'b1; #1;
        check("noval.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("noval.req", 32'(mem_req), 32'd0);
        mem_read = 1'b0;

        // Directed test-plan accesses.
        run_op("lw100",  1, 0, 2'b10, 0, 32'h100, 32'h0,        3,  32'hDEAD_BEEF);
        run_op("lb103",  1, 0, 2'b00, 0, 32'h103, 32'h0,        0,  32'h80FF_FFFF);
        run_op("lbu103", 1, 0, 2'b00, 1, 32'h103, 32'h0,        0,  32'h80FF_FFFF);
        run_op("sh202",  0, 1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 1, 32'h0);
        run_op("lh202",  1, 0, 2'b01, 0, 32'h202, 32'h0,        2,  32'h9ABC_1234);
        run_op("lhu200", 1, 0, 2'b01, 1, 32'h200, 32'h0,        0,  32'h1234_F00D);
        run_op("sb301",  0, 1, 2'b00, 0, 32'h301, 32'hCAFE_BA5E, 0, 32'h0);
        run_op("lw101",  1, 0, 2'b10, 0, 32'h101, 32'h0,        0,  32'h0);
        run_op("rdwr",   1, 1, 2'b10, 0, 32'h100, 32'h0,        0,  32'h0);
        run_op("sz11",   0, 1, 2'b11, 0, 32'h100, 32'h5555_5555, 0, 32'h0);
        run_op("lh201",  1, 0, 2'b01, 0, 32'h201, 32'h0,        0,  32'h0);
        run_op("tmo",    1, 0, 2'b10, 0, 32'h400, 32'h0,        99, 32'h1111_1111);
        run_op("ack4th", 1, 0, 2'b10, 0, 32'h404, 32'h0,        TO - 1, 32'h2222_2222);

        // Reset in the middle of a transaction.
        op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h300;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("rstmid.req_on", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_load = 32'h0;
        check("rstmid.req_off", 32'(mem_req), 32'd0);
        check("rstmid.stall",   32'(stall),   32'd0);
        check("rstmid.done",    32'(done),    32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        repeat (2) begin
            @(posedge clk); #1;
            check("late_ack.done", 32'(done),    32'd0);
            check("late_ack.req",  32'(mem_req), 32'd0);
            check("late_ack.load", load_data,    exp_load);
        end
        mem_ack = 1'b0;
        run_op("lw_after_rst", 1, 0, 2'b10, 0, 32'h500, 32'h0, 1, 32'h0BAD_F00D);

        // Randomized accesses.
        for (int i = 0; i < 60; i++) begin
            int          r, s;
            bit          rd, wr;
            logic [1:0]  sz;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            rd = (r <= 5);
            wr = (r == 0) || (r >= 6);
            s  = $urandom_range(0, 9);
            sz = (s == 9) ? 2'b11 : 2'(s % 3);
            a  = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            run_op("rand", rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 5), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
